lfsr: RTL and testbench



---
 rtl/lfsr.sv | 101 ++++++++++
 tb/tb_lfsr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr -- free-running Fibonacci LFSR, XNOR feedback, maximal-length taps.
//
// Instanced by the obstacle controller. 2-bit instances give the vertical
// lane and 3-bit instances give the obstacle type. The register advances
// one step on every rising clock edge while reset is high. The state
// register drives the output directly.
//
// Parameters:
//   N     register width, 2..16. Any other value stops elaboration.
//   SEED  state loaded on reset. It should not be all-ones unless the
//         de Bruijn variant is built.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  synchronous, active-low (0 = load SEED)
//   out    out  N  current LFSR state (registered)
//
// Build option:
//   LFSR_DEBRUIJN_EN  When this macro is defined, the all-ones state is
//                     spliced into the cycle. The result is a de Bruijn
//                     sequence of period 2^N with no lockup state, and the
//                     lockup-recovery path is removed. When the macro is
//                     undefined, the period is 2^N-1 and an all-ones state
//                     is forced to all-zeros on the next edge.
// ---------------------------------------------------------------------------
module lfsr #(
    parameter int unsigned     N    = 3,
    parameter logic [N-1:0]    SEED = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] out
);

    // Width range guard: unsupported widths have no tap entry.
    if (N < 2 || N > 16) begin : g_bad_width
        $error("lfsr: N=%0d unsupported, must be 2..16", N);
    end

    // Tap positions as a bit mask. Bit k-1 is set for each 1-indexed tap k.
    function automatic logic [15:0] tap_mask(input int unsigned width);
        logic [15:0] m;
        case (width)
            2:       m = 16'h0003;  // 2,1
            3:       m = 16'h0006;  // 3,2
            4:       m = 16'h000C;  // 4,3
            5:       m = 16'h0014;  // 5,3
            6:       m = 16'h0030;  // 6,5
            7:       m = 16'h0060;  // 7,6
            8:       m = 16'h00B8;  // 8,6,5,4
            9:       m = 16'h0110;  // 9,5
            10:      m = 16'h0240;  // 10,7
            11:      m = 16'h0500;  // 11,9
            12:      m = 16'h0829;  // 12,6,4,1
            13:      m = 16'h100D;  // 13,4,3,1
            14:      m = 16'h2015;  // 14,5,3,1
            15:      m = 16'h6000;  // 15,14
            16:      m = 16'hD008;  // 16,15,13,4
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam logic [15:0]  MASK_FULL = tap_mask(N);
    localparam logic [N-1:0] TAPS      = MASK_FULL[N-1:0];

    logic [N-1:0] state;
    logic [N-1:0] next_state;
    logic         fb;

    // Every tap set has an even bit count. A chained XNOR of these taps
    // therefore equals the inverted XOR-reduction of the masked state.
    // All-zeros stays in the cycle and all-ones is the lockup point.
    always_comb begin
        fb = ~^(state & TAPS);
`ifdef LFSR_DEBRUIJN_EN
        // This term flips the feedback when the low N-1 bits are all ones.
        // The flip splits 0111.. -> 1111.. -> 1110.., so all-ones becomes a
        // member of the cycle.
        next_state = {state[N-2:0], fb ^ (&state[N-2:0])};
`else
        if (&state) begin
            next_state = '0;
        end else begin
            next_state = {state[N-2:0], fb};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED;
        end else begin
            state <= next_state;
        end
    end

    assign out = state;

endmodule

// File: tb/tb_lfsr.sv
`timescale 1ns/1ps
module tb_lfsr;

    logic        clk;
    logic        reset;
    logic [1:0]  out2;
    logic [2:0]  out3;
    logic [2:0]  out3s;
    logic [15:0] out16;

    int checks;
    int errors;

    lfsr #(.N(2),  .SEED(2'b00))    u_n2  (.clk(clk), .reset(reset), .out(out2));
    lfsr #(.N(3),  .SEED(3'b000))   u_n3  (.clk(clk), .reset(reset), .out(out3));
    lfsr #(.N(3),  .SEED(3'b111))   u_n3s (.clk(clk), .reset(reset), .out(out3s));
    lfsr #(.N(16), .SEED(16'h0000)) u_n16 (.clk(clk), .reset(reset), .out(out16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of edges and should never get here.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release it just after an edge.
    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Expected N=2 outputs after release. Index 0 is the first cycle.
    function automatic logic [1:0] exp2(input int i);
`ifdef LFSR_DEBRUIJN_EN
        case (i % 4)
            0: return 2'b01; 1: return 2'b11; 2: return 2'b10; default: return 2'b00;
        endcase
`else
        case (i % 3)
            0: return 2'b01; 1: return 2'b10; default: return 2'b00;
        endcase
`endif
    endfunction

    function automatic logic [2:0] exp3(input int i);
`ifdef LFSR_DEBRUIJN_EN
        case (i % 8)
            0: return 3'b001; 1: return 3'b011; 2: return 3'b111; 3: return 3'b110;
            4: return 3'b101; 5: return 3'b010; 6: return 3'b100; default: return 3'b000;
        endcase
`else
        case (i % 7)
            0: return 3'b001; 1: return 3'b011; 2: return 3'b110; 3: return 3'b101;
            4: return 3'b010; 5: return 3'b100; default: return 3'b000;
        endcase
`endif
    endfunction

    task automatic test_reset();
        do_reset();
        // Outputs are sampled before the release edge takes effect.
        checks++;
        if (out2 !== 2'b00) begin errors++; $display("FAIL reset_n2: got %b want 00", out2); end
        checks++;
        if (out3 !== 3'b000) begin errors++; $display("FAIL reset_n3: got %b want 000", out3); end
        checks++;
        if (out3s !== 3'b111) begin errors++; $display("FAIL reset_n3_seed7: got %b want 111", out3s); end
        checks++;
        if (out16 !== 16'h0000) begin errors++; $display("FAIL reset_n16: got %h want 0000", out16); end
    endtask

    task automatic test_n2_sequence();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (out2 !== exp2(i)) begin
                errors++;
                $display("FAIL n2_seq[%0d]: got %b want %b", i, out2, exp2(i));
            end
        end
    endtask

    task automatic test_n3_sequence();
        int seen [8];
        int period;
`ifdef LFSR_DEBRUIJN_EN
        period = 8;
`else
        period = 7;
`endif
        for (int v = 0; v < 8; v++) seen[v] = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step();
            if (i < period) seen[out3]++;
            checks++;
            if (out3 !== exp3(i)) begin
                errors++;
                $display("FAIL n3_seq[%0d]: got %b want %b", i, out3, exp3(i));
            end
        end
        for (int v = 0; v < 8; v++) begin
            int want;
            want = (v == 7 && period == 7) ? 0 : 1;
            checks++;
            if (seen[v] != want) begin
                errors++;
                $display("FAIL n3_seen[%0d]: got %0d want %0d", v, seen[v], want);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (out3 !== exp3(3)) begin errors++; $display("FAIL mid_before: got %b want %b", out3, exp3(3)); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (out3 !== 3'b000) begin errors++; $display("FAIL mid_reset: got %b want 000", out3); end
        step();
        checks++;
        if (out3 !== 3'b001) begin errors++; $display("FAIL mid_resume: got %b want 001", out3); end
    endtask

    task automatic test_lockup();
        logic [2:0] want [4];
`ifdef LFSR_DEBRUIJN_EN
        want[0] = 3'b110; want[1] = 3'b101; want[2] = 3'b010; want[3] = 3'b100;
`else
        want[0] = 3'b000; want[1] = 3'b001; want[2] = 3'b011; want[3] = 3'b110;
`endif
        do_reset();
        checks++;
        if (out3s !== 3'b111) begin errors++; $display("FAIL lockup_seed: got %b want 111", out3s); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out3s !== want[i]) begin
                errors++;
                $display("FAIL lockup[%0d]: got %b want %b", i, out3s, want[i]);
            end
        end
    endtask

    task automatic test_n16_period();
        int period;
        int early_zero;
        int ones_seen;
        int ones_want;
`ifdef LFSR_DEBRUIJN_EN
        period = 65536; ones_want = 1;
`else
        period = 65535; ones_want = 0;
`endif
        early_zero = 0;
        ones_seen  = 0;
        do_reset();
        for (int i = 1; i <= period; i++) begin
            step();
            if (i < period && out16 == 16'h0000) early_zero++;
            if (out16 == 16'hFFFF) ones_seen++;
        end
        checks++;
        if (out16 !== 16'h0000) begin errors++; $display("FAIL n16_return: got %h want 0000", out16); end
        checks++;
        if (early_zero != 0) begin errors++; $display("FAIL n16_early_zero: got %0d want 0", early_zero); end
        checks++;
        if (ones_seen != ones_want) begin
            errors++;
            $display("FAIL n16_all_ones: got %0d want %0d", ones_seen, ones_want);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        step();
        test_reset();
        test_n2_sequence();
        test_n3_sequence();
        test_mid_reset();
        test_lockup();
        test_n16_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
